// File: rtl/servo_pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : servo_pwm_pkg
//  Purpose  : Shared state encoding and default pulse limits for the servo
//             PWM capture path (limits also used by the PWM generator).
//  Revision : 1.0 - initial release
// ============================================================================
package servo_pwm_pkg;

   // Capture FSM states
   typedef enum logic [1:0] {
      ST_ARM       = 2'd0,
      ST_WAIT_RISE = 2'd1,
      ST_HIGH      = 2'd2,
      ST_LOW       = 2'd3
   } state_e;

   // Default accepted pulse window and loss-of-signal interval, in us
   localparam int DEF_MIN_US     = 500;
   localparam int DEF_MAX_US     = 2500;
   localparam int DEF_TIMEOUT_US = 50000;

endpackage : servo_pwm_pkg
`default_nettype wire

// File: rtl/servo_pwm_sync.sv
`default_nettype none
// ============================================================================
//  Module   : servo_pwm_sync
//  Purpose  : Two-flop synchroniser for the PWM pin followed by an edge
//             register; reports the synchronised level and rise/fall pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module servo_pwm_sync (
   input  logic clk,
   input  logic rst,
   input  logic pin_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic edge_q;

   // Flops reset to 1 so a pin that is already high at reset release never
   // looks like a fresh rising edge; a low pin shows up as a harmless fall.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         edge_q <= 1'b1;
      end else begin
         meta_q <= pin_i;
         sync_q <= meta_q;
         edge_q <= sync_q;
      end
   end

   assign level_o = sync_q;
   assign rise_o  = sync_q & ~edge_q;
   assign fall_o  = ~sync_q & edge_q;

endmodule : servo_pwm_sync
`default_nettype wire

// File: rtl/servo_pwm_capture.sv
`default_nettype none
// ============================================================================
//  Module   : servo_pwm_capture
//  Purpose  : Times servo PWM high pulses and rising-to-rising periods in
//             1 us units, range-checks the width and publishes results with
//             a one-cycle strobe; flags loss of signal.
//  Revision : 1.0 - initial release
// ============================================================================
module servo_pwm_capture
   import servo_pwm_pkg::*;
#(
   parameter int CLKS_PER_US = 100,
   parameter int CNT_W       = 16,
   parameter int MIN_US      = DEF_MIN_US,
   parameter int MAX_US      = DEF_MAX_US,
   parameter int TIMEOUT_US  = DEF_TIMEOUT_US
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pwm_in_i,
   output logic [CNT_W-1:0] width_us_o,
   output logic [CNT_W-1:0] period_us_o,
   output logic             width_valid_o,
   output logic             range_err_o,
   output logic             signal_lost_o
);

   localparam int               PRE_W      = $clog2(CLKS_PER_US);
   localparam logic [PRE_W-1:0] C_PRE_LAST = PRE_W'(CLKS_PER_US - 1);
   localparam logic [CNT_W-1:0] C_MIN      = CNT_W'(MIN_US);
   localparam logic [CNT_W-1:0] C_MAX      = CNT_W'(MAX_US);
   localparam logic [CNT_W-1:0] C_TIMEOUT  = CNT_W'(TIMEOUT_US);

   logic             w_level;
   logic             w_rise;
   logic             w_fall;
   logic             w_tick;
   logic             w_timeout;

   state_e           state_q;
   logic [PRE_W-1:0] pre_q,    pre_d;
   logic [CNT_W-1:0] us_cnt_q, us_cnt_d;
   logic [CNT_W-1:0] hi_cnt_q;
   logic [CNT_W-1:0] per_pend_q;
   logic             per_pend_vld_q;
   logic             decide_q;
   logic [CNT_W-1:0] width_us_q;
   logic [CNT_W-1:0] period_us_q;
   logic             width_valid_q;
   logic             range_err_q;
   logic             signal_lost_q;

   servo_pwm_sync u_sync (
      .clk     (clk),
      .rst     (rst),
      .pin_i   (pwm_in_i),
      .level_o (w_level),
      .rise_o  (w_rise),
      .fall_o  (w_fall)
   );

   // Free-running prescaler and saturating microsecond counter next-state
   always_comb begin
      w_tick    = (pre_q == C_PRE_LAST);
      pre_d     = w_tick ? '0 : pre_q + PRE_W'(1);
      us_cnt_d  = us_cnt_q;
      if (w_tick && (us_cnt_q != '1)) begin
         us_cnt_d = us_cnt_q + CNT_W'(1);
      end
      w_timeout = (us_cnt_q >= C_TIMEOUT);
   end

   // Capture FSM, counters, width decision and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_ARM;
         pre_q          <= '0;
         us_cnt_q       <= '0;
         hi_cnt_q       <= '0;
         per_pend_q     <= '0;
         per_pend_vld_q <= 1'b0;
         decide_q       <= 1'b0;
         width_us_q     <= '0;
         period_us_q    <= '0;
         width_valid_q  <= 1'b0;
         range_err_q    <= 1'b0;
         signal_lost_q  <= 1'b1;
      end else begin
         pre_q         <= pre_d;
         us_cnt_q      <= us_cnt_d;
         width_valid_q <= 1'b0;
         range_err_q   <= 1'b0;
         decide_q      <= 1'b0;

         // Width decision runs the cycle after the fall was latched
         if (decide_q) begin
            if ((hi_cnt_q >= C_MIN) && (hi_cnt_q <= C_MAX)) begin
               width_us_q    <= hi_cnt_q;
               width_valid_q <= 1'b1;
               signal_lost_q <= 1'b0;
               if (per_pend_vld_q) begin
                  period_us_q <= per_pend_q;
               end
            end else begin
               range_err_q <= 1'b1;
            end
         end

         case (state_q)
            ST_ARM: begin
               pre_q          <= '0;
               us_cnt_q       <= '0;
               per_pend_vld_q <= 1'b0;
               if (!w_level) begin
                  state_q <= ST_WAIT_RISE;
               end
            end
            ST_WAIT_RISE: begin
               if (w_timeout) begin
                  signal_lost_q <= 1'b1;
                  state_q       <= ST_ARM;
               end else if (w_rise) begin
                  pre_q    <= '0;
                  us_cnt_q <= '0;
                  state_q  <= ST_HIGH;
               end
            end
            ST_HIGH: begin
               if (w_timeout) begin
                  signal_lost_q <= 1'b1;
                  state_q       <= ST_ARM;
               end else if (w_fall) begin
                  hi_cnt_q <= us_cnt_q;
                  decide_q <= 1'b1;
                  state_q  <= ST_LOW;
               end
            end
            ST_LOW: begin
               if (w_timeout) begin
                  signal_lost_q <= 1'b1;
                  state_q       <= ST_ARM;
               end else if (w_rise) begin
                  per_pend_q     <= us_cnt_q;
                  per_pend_vld_q <= 1'b1;
                  pre_q          <= '0;
                  us_cnt_q       <= '0;
                  state_q        <= ST_HIGH;
               end
            end
            default: state_q <= ST_ARM;
         endcase
      end
   end

   assign width_us_o    = width_us_q;
   assign period_us_o   = period_us_q;
   assign width_valid_o = width_valid_q;
   assign range_err_o   = range_err_q;
   assign signal_lost_o = signal_lost_q;

endmodule : servo_pwm_capture
`default_nettype wire
